fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Fetch stage that sits directly upstream of instruction_memory. It owns the program counter and drives instruction_memory's 8-bit addr. It pairs each returned 32-bit word with its PC and presents the result to decode through an IF/ID register. The block compensates for the memory's one-cycle registered read and supports stall (hold) and flush (branch redirect) without losing or duplicating instructions.

Parameters:
ADDR_W, 8, PC and instruction memory address width
INSTR_W, 32, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  decode cannot accept; hold PC and IF/ID contents
flush  in  1  taken branch from downstream (brn and similar); redirect to branch_target
branch_target  in  ADDR_W  redirect address, valid when flush=1
imem_addr  out  ADDR_W  to instruction_memory addr (combinational mux)
imem_data  in  INSTR_W  from instruction_memory data_out; holds word for the address sampled at the previous edge
if_valid  out  1  if_instr/if_pc hold a real fetched instruction
if_instr  out  INSTR_W  fetched instruction to decode
if_pc  out  ADDR_W  address of if_instr

Behaviour:
- Internal state: pc (next address to request); req_pc/req_valid (address whose data sits on imem_data).
- Reset (reset=0, takes effect immediately, no clock needed): pc=RESET_PC, req_pc=0, req_valid=0, if_valid=0, if_instr=0, if_pc=0. imem_data is X after reset; req_valid=0 masks it.
- imem_addr mux, in priority order: flush ? branch_target : stall ? req_pc : pc.
- Normal cycle (no stall, no flush), at each edge:
  - pc <= pc+1
  - req_pc <= pc, req_valid <= 1
  - if_instr <= imem_data, if_pc <= req_pc, if_valid <= req_valid
- Latency: an address reaches if_pc/if_instr 2 edges after it first appears on imem_addr.
- After reset release, first edge: req_valid=1. Second edge: if_valid=1, if_pc=RESET_PC.
- Stall (flush=0):
  - pc, req_pc, req_valid, if_* all hold.
  - Memory re-reads req_pc, so imem_data stays valid for the in-flight word. Nothing is dropped.
- Flush (has priority over stall):
  - pc <= branch_target+1, req_pc <= branch_target, req_valid <= 1, if_valid <= 0.
  - if_instr/if_pc may take don't-care values while if_valid=0; the bench must not check them.
  - The wrong-path word on imem_data is discarded. The first target instruction appears one edge later.
- Wrap-around: pc arithmetic is modulo 2^ADDR_W; 255+1 = 0, and branch_target = 255 gives pc <= 0.
- No NOP insertion or hazard detection here. Zero words (NOP padding) pass through as ordinary instructions with if_valid=1.
- Reset asserted mid-stall or mid-flush: reset wins; the next fetch after release is RESET_PC.

Decomposition:
- Shared package: ADDR_W, INSTR_W, RESET_PC, NOP_INSTR=32'h0, and the opcode field position [31:28] for downstream use.
- One natural sub-module: if_id_reg, holding if_valid/if_instr/if_pc with load, hold and squash controls and the async active-low reset.
- PC and request tracking stay in fetch_unit.

Test Plan:
1. Bench setup: instantiate with instruction_memory holding its program.
2. Reset release, stall=0, flush=0 -> edge 2: if_valid=1, if_pc=0, if_instr=32'h71041000. Edge 7: if_pc=5, if_instr=32'h5104FC00. if_pc increments by 1 every edge.
3. Assert stall for 3 edges while req_pc=10 -> if_*, pc and req_pc hold. After release the next edge gives if_pc=10, if_instr=32'h41420C00, then 11, 12. No gaps, no duplicates.
4. flush=1, branch_target=37 while pc=50 -> next edge: if_valid=0, imem_addr was 37. Following edge: if_valid=1, if_pc=37, if_instr=32'hB00A0000. Then if_pc=38.
5. flush=1 and stall=1 in the same cycle, target=15 -> flush wins: if_valid=0, then if_pc=15 with 32'hF2400800 regardless of stall.
6. Flush to 254 then run -> if_pc sequence 254, 255, 0, 1. Then assert reset asynchronously mid-cycle -> if_valid=0, if_pc=0, if_instr=0 immediately. Restart matches scenario 2.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage widths, reset PC and instruction field positions.
// Imported by the fetch unit, its IF/ID register, the bus interface and downstream decode.
package fetch_unit_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 32;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam addr_t  RESET_PC  = '0;
    localparam instr_t NOP_INSTR = 32'h0;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 28;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input instr_t instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: stall/flush controls, instruction memory link and IF/ID outputs.
// master = fetch unit, slave = surrounding pipeline and instruction memory.
interface fetch_unit_if;

    logic                   stall;
    logic                   flush;
    fetch_unit_pkg::addr_t  branch_target;
    fetch_unit_pkg::addr_t  imem_addr;
    fetch_unit_pkg::instr_t imem_data;
    logic                   if_valid;
    fetch_unit_pkg::instr_t if_instr;
    fetch_unit_pkg::addr_t  if_pc;

    modport master (
        input  stall, flush, branch_target, imem_data,
        output imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output stall, flush, branch_target, imem_data,
        input  imem_addr, if_valid, if_instr, if_pc
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: latches fetched word and PC on load, holds otherwise.
// Latency 1 edge; squash clears only valid, leaving instr/pc as don't-care.
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   load,
    input  logic   squash,
    input  logic   in_valid,
    input  instr_t in_instr,
    input  addr_t  in_pc,
    output logic   valid,
    output instr_t instr,
    output addr_t  pc
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (squash) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= in_valid;
            instr <= in_instr;
            pc    <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and pairs each word with its PC.
// Latency 2 edges addr->IF/ID; stall holds all state, flush redirects and squashes IF/ID.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    addr_t pc;
    addr_t req_pc;
    logic  req_valid;
    logic  load;

    // On stall the memory re-reads req_pc so imem_data keeps the in-flight word.
    assign bus.imem_addr = bus.flush ? bus.branch_target :
                           bus.stall ? req_pc : pc;

    assign load = !bus.stall && !bus.flush;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            req_pc    <= '0;
            req_valid <= 1'b0;
        end else if (bus.flush) begin
            pc        <= bus.branch_target + addr_t'(1);
            req_pc    <= bus.branch_target;
            req_valid <= 1'b1;
        end else if (!bus.stall) begin
            pc        <= pc + addr_t'(1);
            req_pc    <= pc;
            req_valid <= 1'b1;
        end
    end

    if_id_reg u_if_id (
        .clock    (clock),
        .reset    (reset),
        .load     (load),
        .squash   (bus.flush),
        .in_valid (req_valid),
        .in_instr (bus.imem_data),
        .in_pc    (req_pc),
        .valid    (bus.if_valid),
        .instr    (bus.if_instr),
        .pc       (bus.if_pc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against an instruction-stream model
// with a registered-read instruction memory.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    instr_t mem [256];

    always @(posedge clock) bus.imem_data <= mem[bus.imem_addr];

    // Model: m_pc is the next address due at IF/ID; m_fresh means no request issued since reset.
    addr_t  m_pc;
    logic   m_fresh;
    logic   m_valid;
    addr_t  m_if_pc;
    instr_t m_instr;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_fresh = 1'b1;
        m_valid = 1'b0;
        m_if_pc = '0;
        m_instr = '0;
    endtask

    function automatic addr_t exp_addr(input logic s, input logic f, input addr_t t);
        addr_t r;
        if (f)            r = t;
        else if (s)       r = m_fresh ? addr_t'(0) : m_pc;
        else if (m_fresh) r = m_pc;
        else              r = m_pc + addr_t'(1);
        return r;
    endfunction

    task automatic check_outputs();
        check("if_valid", {31'b0, bus.if_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("if_pc", {24'b0, bus.if_pc}, {24'b0, m_if_pc});
            check("if_instr", bus.if_instr, m_instr);
        end
    endtask

    task automatic step(input logic s, input logic f, input addr_t t);
        @(negedge clock);
        bus.stall         = s;
        bus.flush         = f;
        bus.branch_target = t;
        #1;
        check("imem_addr", {24'b0, bus.imem_addr}, {24'b0, exp_addr(s, f, t)});
        @(posedge clock);
        if (f) begin
            m_pc    = t;
            m_fresh = 1'b0;
            m_valid = 1'b0;
        end else if (!s) begin
            if (m_fresh) begin
                m_fresh = 1'b0;
                m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_if_pc = m_pc;
                m_instr = mem[m_pc];
                m_pc    = m_pc + addr_t'(1);
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic expect_word(input string tag, input addr_t pc, input instr_t instr);
        check({tag, "_valid"}, {31'b0, bus.if_valid}, 32'd1);
        check({tag, "_pc"}, {24'b0, bus.if_pc}, {24'b0, pc});
        check({tag, "_instr"}, bus.if_instr, instr);
    endtask

    initial begin
        addr_t wrap_seq [4];
        wrap_seq[0] = 8'd254;
        wrap_seq[1] = 8'd255;
        wrap_seq[2] = 8'd0;
        wrap_seq[3] = 8'd1;

        for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 7) == 0) ? NOP_INSTR : instr_t'($urandom);
        mem[0]  = 32'h71041000;
        mem[3]  = NOP_INSTR;
        mem[5]  = 32'h5104FC00;
        mem[10] = 32'h41420C00;
        mem[15] = 32'hF2400800;
        mem[37] = 32'hB00A0000;

        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_target = '0;
        model_reset();

        #12;
        check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_pc", {24'b0, bus.if_pc}, 32'd0);
        check("rst_instr", bus.if_instr, 32'd0);
        check("rst_imem_addr", {24'b0, bus.imem_addr}, {24'b0, RESET_PC});

        @(posedge clock);
        #2 reset = 1'b1;

        // Straight-line fetch from reset, then a 3-edge stall with req_pc=10.
        for (int i = 1; i <= 11; i++) begin
            step(1'b0, 1'b0, '0);
            if (i == 2) expect_word("first", 8'd0, 32'h71041000);
            if (i == 7) expect_word("edge7", 8'd5, 32'h5104FC00);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        expect_word("stall_hold", 8'd9, mem[9]);
        step(1'b0, 1'b0, '0);
        expect_word("post_stall", 8'd10, 32'h41420C00);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        expect_word("post_stall2", 8'd12, mem[12]);

        // Redirect to 37 while pc=50.
        while (m_pc != 8'd49) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 8'd37);
        check("flush_bubble", {31'b0, bus.if_valid}, 32'd0);
        step(1'b0, 1'b0, '0);
        expect_word("br37", 8'd37, 32'hB00A0000);
        step(1'b0, 1'b0, '0);
        expect_word("br38", 8'd38, mem[38]);

        // Flush outranks a simultaneous stall.
        step(1'b1, 1'b1, 8'd15);
        check("fs_bubble", {31'b0, bus.if_valid}, 32'd0);
        step(1'b0, 1'b0, '0);
        expect_word("fs15", 8'd15, 32'hF2400800);

        // PC wrap-around.
        step(1'b0, 1'b1, 8'd254);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, '0);
            expect_word("wrap", wrap_seq[i], mem[wrap_seq[i]]);
        end

        // Asynchronous reset mid-cycle while stall and flush are both high.
        bus.stall         = 1'b1;
        bus.flush         = 1'b1;
        bus.branch_target = 8'd99;
        #1 reset = 1'b0;
        #1;
        model_reset();
        check("arst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("arst_pc", {24'b0, bus.if_pc}, 32'd0);
        check("arst_instr", bus.if_instr, 32'd0);
        #1 reset = 1'b1;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        expect_word("restart", 8'd0, 32'h71041000);

        // Randomized stall/flush traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, addr_t'($urandom_range(0, 255)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
